// File: rtl/nlp16af_bus_responder.sv
// rtl/nlp16af_bus_responder.sv - nlp16af memory-bus target: word RAM plus GPIO/timer/RX FIFO/TX I/O page
module nlp16af_bus_responder #(
    parameter int          RAM_AW   = 10,
    parameter int          RX_DEPTH = 4,
    parameter logic [15:0] IO_BASE  = 16'hFF00
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    input  logic [15:0] i_gpio,
    output logic [15:0] o_gpio,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);

    localparam int          PW        = $clog2(RX_DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [16:0] RAM_WORDS = 17'(2 ** RAM_AW);
    localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_TIMER_LO = 3'd2;
    localparam logic [2:0] OFF_TIMER_HI = 3'd3;
    localparam logic [2:0] OFF_RX_STAT  = 3'd4;
    localparam logic [2:0] OFF_RX_DATA  = 3'd5;
    localparam logic [2:0] OFF_TX_DATA  = 3'd6;
    localparam logic [2:0] OFF_BUS_ERR  = 3'd7;

    logic [15:0]   ram [0:2**RAM_AW-1];
    logic [7:0]    rx_mem [0:RX_DEPTH-1];

    logic [15:0]   gpio_q, gpio_d;
    logic [15:0]   gsync1_q, gsync1_d;
    logic [15:0]   gsync2_q, gsync2_d;
    logic [31:0]   timer_q, timer_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          err_q, err_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [PW-1:0] rx_wr_q, rx_wr_d;
    logic [PW-1:0] rx_rd_q, rx_rd_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;

    logic [15:0]       io_rel;
    logic [2:0]        io_off;
    logic              io_hit, ram_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_en, proto_err;
    logic              rx_push, rx_pop;
    logic              tx_wr, tx_drop, tx_hs;

    // Page decode by subtraction so IO_BASE needs no particular alignment.
    assign io_rel    = i_addr - IO_BASE;
    assign io_hit    = (io_rel[15:3] == 13'd0);
    assign io_off    = io_rel[2:0];
    assign ram_hit   = !io_hit && ({1'b0, i_addr} < RAM_WORDS);
    assign ram_idx   = i_addr[RAM_AW-1:0];
    assign wr_en     = i_wr && !i_rd;
    assign proto_err = i_rd && i_wr;

    assign o_rx_ready = (rx_cnt_q != FULL_CNT);
    assign rx_push    = i_rx_valid && o_rx_ready;
    assign rx_pop     = i_rd && io_hit && (io_off == OFF_RX_DATA) && (rx_cnt_q != '0);

    assign tx_wr   = wr_en && io_hit && (io_off == OFF_TX_DATA);
    assign tx_hs   = tx_valid_q && i_tx_ready;
    assign tx_drop = tx_wr && tx_valid_q && !i_tx_ready;

    assign o_gpio     = gpio_q;
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;

    always_comb begin
        o_rdata = 16'h0000;
        if (i_rd) begin
            if (io_hit) begin
                case (io_off)
                    OFF_GPIO_OUT: o_rdata = gpio_q;
                    OFF_GPIO_IN:  o_rdata = gsync2_q;
                    OFF_TIMER_LO: o_rdata = timer_q[15:0];
                    OFF_TIMER_HI: o_rdata = shadow_q;
                    OFF_RX_STAT:  o_rdata = 16'(rx_cnt_q);
                    OFF_RX_DATA:  o_rdata = (rx_cnt_q != '0) ? {8'h00, rx_mem[rx_rd_q]} : 16'h0000;
                    OFF_TX_DATA:  o_rdata = {15'd0, tx_valid_q};
                    default:      o_rdata = {15'd0, err_q};
                endcase
            end else if (ram_hit) begin
                o_rdata = ram[ram_idx];
            end
        end
    end

    always_comb begin
        gpio_d     = gpio_q;
        gsync1_d   = i_gpio;
        gsync2_d   = gsync1_q;
        timer_d    = timer_q + 32'd1;
        shadow_d   = shadow_q;
        err_d      = err_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rx_wr_d    = rx_wr_q + PW'(rx_push);
        rx_rd_d    = rx_rd_q + PW'(rx_pop);
        rx_cnt_d   = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

        if (wr_en && io_hit && (io_off == OFF_GPIO_OUT)) begin
            gpio_d = i_wdata;
        end
        // Latching the upper half on the LO read makes LO-then-HI a coherent 32-bit sample.
        if (i_rd && io_hit && (io_off == OFF_TIMER_LO)) begin
            shadow_d = timer_q[31:16];
        end

        if (tx_wr && !tx_drop) begin
            tx_valid_d = 1'b1;
            tx_data_d  = i_wdata[7:0];
        end else if (tx_hs) begin
            tx_valid_d = 1'b0;
        end

        if (wr_en && io_hit && (io_off == OFF_BUS_ERR)) begin
            err_d = 1'b0;
        end
        if (proto_err || tx_drop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gpio_q     <= '0;
            gsync1_q   <= '0;
            gsync2_q   <= '0;
            timer_q    <= '0;
            shadow_q   <= '0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
        end else begin
            gpio_q     <= gpio_d;
            gsync1_q   <= gsync1_d;
            gsync2_q   <= gsync2_d;
            timer_q    <= timer_d;
            shadow_q   <= shadow_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

    // Storage arrays carry no reset; only the FIFO pointers/count define occupancy.
    always_ff @(posedge i_clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_q] <= i_rx_data;
        end
        if (wr_en && ram_hit) begin
            ram[ram_idx] <= i_wdata;
        end
    end

endmodule

// File: tb/tb_nlp16af_bus_responder.sv
// tb/tb_nlp16af_bus_responder.sv - self-checking bench for nlp16af_bus_responder
module tb_nlp16af_bus_responder;

    localparam logic [15:0] A_GPIO_OUT = 16'hFF00;
    localparam logic [15:0] A_TIMER_LO = 16'hFF02;
    localparam logic [15:0] A_TIMER_HI = 16'hFF03;
    localparam logic [15:0] A_RX_STAT  = 16'hFF04;
    localparam logic [15:0] A_RX_DATA  = 16'hFF05;
    localparam logic [15:0] A_TX_DATA  = 16'hFF06;
    localparam logic [15:0] A_BUS_ERR  = 16'hFF07;

    logic        clk, rst_n;
    logic        i_rd, i_wr;
    logic [15:0] i_addr, i_wdata, o_rdata;
    logic [15:0] i_gpio, o_gpio;
    logic        i_rx_valid, o_rx_ready;
    logic [7:0]  i_rx_data;
    logic        o_tx_valid, i_tx_ready;
    logic [7:0]  o_tx_data;

    int n_checks = 0;
    int n_errors = 0;

    nlp16af_bus_responder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd       (i_rd),
        .i_wr       (i_wr),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .i_gpio     (i_gpio),
        .o_gpio     (o_gpio),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .o_rx_ready (o_rx_ready),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bus state as plain values, FIFO as a queue.
    logic [15:0] m_ram [0:1023];
    bit          m_known [0:1023];
    logic [7:0]  m_rxq [$];
    logic [15:0] m_gpio, m_s1, m_s2, m_shadow;
    logic [31:0] m_timer;
    logic        m_err, m_txv;
    logic [7:0]  m_txd;

    initial begin
        for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    end

    function automatic bit in_io(input logic [15:0] a);
        return (a >= 16'hFF00) && (a <= 16'hFF07);
    endfunction

    function automatic logic [16:0] exp_read();
        int off;
        if (!i_rd) return {1'b1, 16'h0000};
        if (in_io(i_addr)) begin
            off = int'(i_addr - 16'hFF00);
            case (off)
                0: return {1'b1, m_gpio};
                1: return {1'b1, m_s2};
                2: return {1'b1, m_timer[15:0]};
                3: return {1'b1, m_shadow};
                4: return {1'b1, 16'(m_rxq.size())};
                5: return {1'b1, (m_rxq.size() > 0) ? {8'h00, m_rxq[0]} : 16'h0000};
                6: return {1'b1, 15'd0, m_txv};
                default: return {1'b1, 15'd0, m_err};
            endcase
        end
        if (i_addr < 16'd1024) return {m_known[i_addr[9:0]], m_ram[i_addr[9:0]]};
        return {1'b1, 16'h0000};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit we, io, ready_pre, drop;
        int off;
        if (!rst_n) begin
            m_gpio = 0; m_s1 = 0; m_s2 = 0; m_shadow = 0; m_timer = 0;
            m_err = 0; m_txv = 0; m_txd = 0;
            m_rxq.delete();
        end else begin
            we        = i_wr && !i_rd;
            io        = in_io(i_addr);
            off       = int'(i_addr - 16'hFF00);
            ready_pre = m_rxq.size() < 4;
            drop      = 0;
            if (i_rd && io && off == 2) m_shadow = m_timer[31:16];
            if (i_rd && io && off == 5 && m_rxq.size() > 0) void'(m_rxq.pop_front());
            if (i_rx_valid && ready_pre) m_rxq.push_back(i_rx_data);
            if (we && io && off == 6) begin
                if (m_txv && !i_tx_ready) drop = 1;
                else begin m_txv = 1; m_txd = i_wdata[7:0]; end
            end else if (m_txv && i_tx_ready) begin
                m_txv = 0;
            end
            if (we && io && off == 7) m_err = 0;
            if (drop || (i_rd && i_wr)) m_err = 1;
            if (we && io && off == 0) m_gpio = i_wdata;
            if (we && i_addr < 16'd1024) begin
                m_ram[i_addr[9:0]]   = i_wdata;
                m_known[i_addr[9:0]] = 1'b1;
            end
            m_s2    = m_s1;
            m_s1    = i_gpio;
            m_timer = m_timer + 32'd1;
        end
    end

    always @(negedge clk) begin : compare
        logic [16:0] er;
        er = exp_read();
        if (er[16]) check("rdata", {16'h0, o_rdata}, {16'h0, er[15:0]});
        check("rx_ready", {31'h0, o_rx_ready}, {31'h0, m_rxq.size() < 4});
        check("tx_valid", {31'h0, o_tx_valid}, {31'h0, m_txv});
        check("tx_data", {24'h0, o_tx_data}, {24'h0, m_txd});
        check("gpio", {16'h0, o_gpio}, {16'h0, m_gpio});
    end

    task automatic cyc(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        i_rd = rd; i_wr = wr; i_addr = a; i_wdata = d;
        #3;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        rst_n = 0; i_rd = 0; i_wr = 0; i_addr = 0; i_wdata = 0;
        i_gpio = 0; i_rx_valid = 0; i_rx_data = 0; i_tx_ready = 0;
        #2;
        check("rst_gpio", {16'h0, o_gpio}, 32'h0);
        check("rst_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, o_rx_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;

        // RAM window and out-of-range
        cyc(0, 1, 16'h0012, 16'hBEEF);
        cyc(0, 1, 16'h0000, 16'h1111);
        cyc(1, 0, 16'h0012, 16'h0000);
        check("t1_ram_rd", {16'h0, o_rdata}, 32'hBEEF);
        cyc(1, 0, 16'h0800, 16'h0000);
        check("t1_oor_rd", {16'h0, o_rdata}, 32'h0);
        cyc(0, 1, 16'h0800, 16'h2222);
        cyc(1, 0, 16'h0000, 16'h0000);
        check("t1_no_alias", {16'h0, o_rdata}, 32'h1111);

        // RX FIFO fill, hold, drain
        i_rx_valid = 1;
        i_rx_data = 8'h11; idle();
        i_rx_data = 8'h22; idle();
        i_rx_data = 8'h33; idle();
        i_rx_data = 8'h44; idle();
        i_rx_data = 8'h55;
        cyc(1, 0, A_RX_STAT, 16'h0);
        check("t2_full_ready", {31'h0, o_rx_ready}, 32'h0);
        check("t2_stat4", {16'h0, o_rdata}, 32'h4);
        i_rx_valid = 0;
        cyc(1, 0, A_RX_DATA, 16'h0); check("t2_pop1", {16'h0, o_rdata}, 32'h11);
        cyc(1, 0, A_RX_DATA, 16'h0); check("t2_pop2", {16'h0, o_rdata}, 32'h22);
        cyc(1, 0, A_RX_DATA, 16'h0); check("t2_pop3", {16'h0, o_rdata}, 32'h33);
        cyc(1, 0, A_RX_DATA, 16'h0); check("t2_pop4", {16'h0, o_rdata}, 32'h44);
        cyc(1, 0, A_RX_DATA, 16'h0); check("t2_pop_empty", {16'h0, o_rdata}, 32'h0);
        i_rx_valid = 1;
        idle();
        check("t2_ready_again", {31'h0, o_rx_ready}, 32'h1);
        i_rx_valid = 0;
        cyc(1, 0, A_RX_STAT, 16'h0); check("t2_stat1", {16'h0, o_rdata}, 32'h1);
        cyc(1, 0, A_RX_DATA, 16'h0); check("t2_pop5", {16'h0, o_rdata}, 32'h55);

        // TX holding register
        i_tx_ready = 0;
        cyc(0, 1, A_BUS_ERR, 16'h0);
        cyc(0, 1, A_TX_DATA, 16'h005A);
        idle();
        check("t3_tx_valid", {31'h0, o_tx_valid}, 32'h1);
        check("t3_tx_data", {24'h0, o_tx_data}, 32'h5A);
        cyc(0, 1, A_TX_DATA, 16'h00A5);
        cyc(1, 0, A_BUS_ERR, 16'h0);
        check("t3_err_set", {16'h0, o_rdata}, 32'h1);
        check("t3_tx_kept", {24'h0, o_tx_data}, 32'h5A);
        i_tx_ready = 1;
        idle();
        check("t3_tx_done", {31'h0, o_tx_valid}, 32'h0);
        i_tx_ready = 0;
        cyc(0, 1, A_BUS_ERR, 16'h0);
        cyc(1, 0, A_BUS_ERR, 16'h0);
        check("t3_err_clr", {16'h0, o_rdata}, 32'h0);

        // Simultaneous read+write
        cyc(0, 1, 16'h0004, 16'h1234);
        cyc(1, 1, 16'h0004, 16'hFFFF);
        check("t5_rdwr_data", {16'h0, o_rdata}, 32'h1234);
        cyc(1, 0, 16'h0004, 16'h0);
        check("t5_ram_kept", {16'h0, o_rdata}, 32'h1234);
        cyc(1, 0, A_BUS_ERR, 16'h0);
        check("t5_err", {16'h0, o_rdata}, 32'h1);

        // Asynchronous reset mid activity
        cyc(0, 1, A_GPIO_OUT, 16'h00A5);
        i_rx_valid = 1; i_rx_data = 8'h77;
        cyc(0, 1, A_TX_DATA, 16'h003C);
        repeat (4) idle();
        check("t6_pre_gpio", {16'h0, o_gpio}, 32'hA5);
        check("t6_pre_tx", {31'h0, o_tx_valid}, 32'h1);
        check("t6_pre_full", {31'h0, o_rx_ready}, 32'h0);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("t6_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        check("t6_rx_ready", {31'h0, o_rx_ready}, 32'h1);
        check("t6_gpio", {16'h0, o_gpio}, 32'h0);
        i_rx_valid = 0; i_rd = 0; i_wr = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;

        // Coherent timer read across the 16-bit boundary
        repeat (32'h10005) @(posedge clk);
        cyc(1, 0, A_TIMER_LO, 16'h0);
        cyc(1, 0, A_TIMER_HI, 16'h0);
        check("t4_timer_hi", {16'h0, o_rdata}, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic rd, wr;
            logic [15:0] a;
            r  = int'($urandom_range(0, 9));
            rd = (r <= 3) || (r == 7);
            wr = (r >= 4 && r <= 7);
            case ($urandom_range(0, 4))
                0, 1: a = 16'hFF00 + 16'($urandom_range(0, 7));
                2:    a = 16'($urandom_range(0, 31));
                3:    a = 16'h0800 + 16'($urandom_range(0, 31));
                default: a = 16'($urandom);
            endcase
            i_rx_valid = 1'($urandom);
            i_rx_data  = 8'($urandom);
            i_tx_ready = 1'($urandom);
            i_gpio     = 16'($urandom);
            cyc(rd, wr, a, 16'($urandom));
        end
        idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
